// File: rtl/zap_prefetch_ctrl.sv
// Instruction prefetch controller: issues sequential word fetches, tracks FIFO
// credit and in-flight fetches, and discards stale responses after a flush.
module zap_prefetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  logic        i_hold,
    input  logic        i_fifo_pop,
    output logic        o_req,
    output logic [31:0] o_addr,
    input  logic        i_ack,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    input  logic        i_rerr,
    output logic        o_wr_valid,
    output logic [31:0] o_wr_instr,
    output logic        o_wr_abort
);

    // Wide enough that occ + outst (at most 2*DEPTH) cannot overflow.
    localparam int unsigned CW = $clog2(DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {RUN, HOLD, ERR} state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [CW-1:0] outst, outst_next;
    logic [CW-1:0] occ, occ_next;
    logic [CW-1:0] drop, drop_next;
    logic          req_next;
    logic [31:0]   addr_next;

    logic          bus_free;
    logic          resp;
    logic          dropping;
    logic          wr;
    logic          pop;
    logic          can_run;
    logic          launch;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst_base;
    logic [CW-1:0] occ_base;
    logic [CW-1:0] drop_base;

    always_comb begin
        bus_free   = !o_req || i_ack;
        // A response with nothing in flight (e.g. straight after reset) is ignored.
        resp       = i_rvalid && (outst != '0);
        dropping   = resp && (drop != '0);
        wr         = resp && !dropping && !i_flush;
        pop        = i_fifo_pop && (occ != '0);

        outst_base = outst - CW'(resp);
        drop_base  = drop - CW'(dropping);
        occ_base   = occ + CW'(resp && !dropping) - CW'(pop);
        fetch_pc   = pc;
        can_run    = (state == RUN);

        // A flush may launch the new stream at once; every fetch still in
        // flight, including a held unacked request, becomes a drop credit.
        if (i_flush) begin
            occ_base  = '0;
            drop_base = outst_base;
            fetch_pc  = i_flush_pc & ~32'h3;
            can_run   = !i_hold;
        end

        launch = can_run && bus_free &&
                 (outst_base < MAX_C) &&
                 ((occ_base + outst_base) < DEPTH_C);

        outst_next = outst_base + CW'(launch);
        occ_next   = occ_base;
        drop_next  = drop_base;
        pc_next    = launch ? fetch_pc + 32'd4 : fetch_pc;
        req_next   = launch || (o_req && !i_ack);
        addr_next  = launch ? fetch_pc : o_addr;
    end

    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = i_hold ? HOLD : RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (wr && i_rerr)  state_next = ERR;
                    else if (i_hold)   state_next = HOLD;
                end
                HOLD: begin
                    if (wr && i_rerr)  state_next = ERR;
                    else if (!i_hold)  state_next = RUN;
                end
                ERR:     state_next = ERR;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= RUN;
            pc         <= RESET_VECTOR;
            outst      <= '0;
            occ        <= '0;
            drop       <= '0;
            o_req      <= 1'b0;
            o_addr     <= RESET_VECTOR;
            o_wr_valid <= 1'b0;
            o_wr_instr <= '0;
            o_wr_abort <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            outst      <= outst_next;
            occ        <= occ_next;
            drop       <= drop_next;
            o_req      <= req_next;
            o_addr     <= addr_next;
            o_wr_valid <= wr;
            if (wr) begin
                o_wr_instr <= i_rdata;
                o_wr_abort <= i_rerr;
            end
        end
    end

endmodule

// File: tb/tb_zap_prefetch_ctrl.sv
// Directed self-checking bench for zap_prefetch_ctrl.
module tb_zap_prefetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        hold;
    logic        pop;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
    logic        wr_valid;
    logic [31:0] wr_instr;
    logic        wr_abort;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        auto_rsp = 1'b0;
    logic [31:0] issued[$];
    logic [31:0] wrq[$];

    zap_prefetch_ctrl #(
        .RESET_VECTOR   (32'h0),
        .DEPTH          (8),
        .MAX_OUTSTANDING(4)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_flush    (flush),
        .i_flush_pc (flush_pc),
        .i_hold     (hold),
        .i_fifo_pop (pop),
        .o_req      (req),
        .o_addr     (addr),
        .i_ack      (ack),
        .i_rvalid   (rvalid),
        .i_rdata    (rdata),
        .i_rerr     (rerr),
        .o_wr_valid (wr_valid),
        .o_wr_instr (wr_instr),
        .o_wr_abort (wr_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; records accepted addresses and FIFO writes, and in auto mode
    // returns each accepted fetch one cycle later with data addr ^ 0x5A5A0000.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = req && ack;
        a   = addr;
        if (acc) issued.push_back(a);
        @(posedge clk);
        #1;
        if (wr_valid) wrq.push_back(wr_instr);
        if (auto_rsp) begin
            rvalid = acc;
            rdata  = a ^ 32'h5A5A_0000;
            rerr   = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0; hold = 1'b0; pop = 1'b0;
        ack = 1'b1; rvalid = 1'b0; rdata = '0; rerr = 1'b0;

        // Test 1: streaming with ack tied high, credit limit, pop releases one fetch
        auto_rsp = 1'b1;
        repeat (2) tick();
        check("rst_req", req, 0);
        check("rst_addr", addr, 32'h0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_instr", wr_instr, 32'h0);
        check("rst_wr_abort", wr_abort, 0);
        rst_n = 1'b1;
        tick();
        check("first_req", req, 1);
        check("first_addr", addr, 32'h0);
        repeat (12) tick();
        check("stream_launches", issued.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < issued.size()) check("stream_addr", issued[i], 32'(4 * i));
        check("stream_writes", wrq.size(), 8);
        if (wrq.size() == 8) begin
            check("stream_wr0", wrq[0], 32'h5A5A_0000);
            check("stream_wr7", wrq[7], 32'h5A5A_001C);
        end
        check("credit_stall_req", req, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pop_req", req, 1);
        check("pop_addr", addr, 32'h20);
        repeat (6) tick();
        check("pop_launches", issued.size(), 9);
        check("pop_writes", wrq.size(), 9);
        if (wrq.size() == 9) check("pop_wr8", wrq[8], 32'h5A5A_0020);
        check("pop_stall_req", req, 0);

        // Test 2: async reset mid-run, request held while ack low
        rst_n = 1'b0;
        #1;
        check("async_rst_req", req, 0);
        auto_rsp = 1'b0; rvalid = 1'b0; ack = 1'b0;
        issued.delete(); wrq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("noack_first_req", req, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("noack_req", req, 1);
            check("noack_addr", addr, 32'h0);
        end
        ack = 1'b1;
        tick();
        check("ack_next_req", req, 1);
        check("ack_next_addr", addr, 32'h4);

        // Test 3: flush with three fetches in flight
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1; ack = 1'b1;
        issued.delete(); wrq.delete();
        tick();
        tick();
        hold = 1'b1;
        tick();
        tick();
        check("hold3_req", req, 0);
        check("hold3_addr", addr, 32'h8);
        flush = 1'b1; flush_pc = 32'h1002; hold = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_req", req, 1);
        check("flush_addr", addr, 32'h1000);
        for (int k = 1; k <= 3; k++) begin
            rvalid = 1'b1; rdata = 32'hDEAD_0000 | 32'(k);
            tick();
            check("stale_dropped", wr_valid, 0);
        end
        rvalid = 1'b1; rdata = 32'h600D_F00D;
        tick();
        rvalid = 1'b0;
        check("fresh_wr_valid", wr_valid, 1);
        check("fresh_wr_instr", wr_instr, 32'h600D_F00D);
        check("fresh_wr_abort", wr_abort, 0);

        // Test 4: flush while a request is pending unacked
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1; ack = 1'b0; flush = 1'b1; flush_pc = 32'h40;
        issued.delete(); wrq.delete();
        tick();
        flush_pc = 32'h2000;
        tick();
        flush = 1'b0;
        check("pend_req", req, 1);
        check("pend_addr", addr, 32'h40);
        repeat (2) tick();
        check("pend_hold_addr", addr, 32'h40);
        ack = 1'b1;
        tick();
        check("redirect_req", req, 1);
        check("redirect_addr", addr, 32'h2000);
        ack = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0040;
        tick();
        check("pend_resp_dropped", wr_valid, 0);
        rvalid = 1'b0; ack = 1'b1;
        tick();
        check("redirect_next_addr", addr, 32'h2004);
        ack = 1'b0; rvalid = 1'b1; rdata = 32'h2000_AAAA;
        tick();
        check("redirect_wr_valid", wr_valid, 1);
        check("redirect_wr_instr", wr_instr, 32'h2000_AAAA);

        // Test 5: bus error response
        rvalid = 1'b0; ack = 1'b1;
        tick();
        rvalid = 1'b1; rerr = 1'b1; rdata = 32'hBAD0_2004;
        tick();
        check("err_wr_valid", wr_valid, 1);
        check("err_wr_abort", wr_abort, 1);
        check("err_wr_instr", wr_instr, 32'hBAD0_2004);
        rvalid = 1'b0; rerr = 1'b0;
        tick();
        check("err_stop_req", req, 0);
        repeat (3) tick();
        check("err_idle_req", req, 0);
        flush = 1'b1; flush_pc = 32'h80;
        tick();
        flush = 1'b0;
        check("err_flush_req", req, 1);
        check("err_flush_addr", addr, 32'h80);

        // Test 6: hold mid-stream across the address wrap
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1; flush = 1'b1; flush_pc = 32'hFFFF_FFF4; ack = 1'b1;
        auto_rsp = 1'b1;
        issued.delete(); wrq.delete();
        tick();
        flush = 1'b0;
        tick();
        hold = 1'b1;
        tick();
        check("hold_last_req", req, 1);
        check("hold_last_addr", addr, 32'hFFFF_FFFC);
        tick();
        check("hold_stop_req", req, 0);
        repeat (2) tick();
        check("hold_writes", wrq.size(), 3);
        if (wrq.size() == 3) check("hold_last_wr", wrq[2], 32'hA5A5_FFFC);
        check("hold_idle_req", req, 0);
        hold = 1'b0;
        for (int n = 0; n < 4 && !req; n++) tick();
        check("resume_req", req, 1);
        check("resume_addr", addr, 32'h0);
        tick();
        check("wrap_launches", issued.size(), 4);
        if (issued.size() == 4) begin
            check("wrap_prev", issued[2], 32'hFFFF_FFFC);
            check("wrap_next", issued[3], 32'h0);
        end

        // Test 7: reset mid-operation, stray response with nothing in flight
        rst_n = 1'b0;
        #1;
        check("midrst_req", req, 0);
        check("midrst_wr_valid", wr_valid, 0);
        auto_rsp = 1'b0; rvalid = 1'b0;
        tick();
        rst_n = 1'b1; ack = 1'b0; rvalid = 1'b1; rdata = 32'hBADB_AD00;
        tick();
        rvalid = 1'b0;
        check("stray_ignored", wr_valid, 0);
        check("stray_req", req, 1);
        check("stray_addr", addr, 32'h0);
        tick();
        check("stray_no_late_write", wr_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
